// File: rtl/riscv_inst_encoder.sv
// RV32I instruction encoder: packs decoded fields and a signed immediate into an
// instruction word, flags unrepresentable immediates, and buffers results in a 2-entry queue.
module riscv_inst_encoder #(
  parameter int CNT_W        = 16,
  parameter bit ERR_ZERO_IMM = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       opcode,
  input  logic [4:0]       rd,
  input  logic [2:0]       funct3,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [6:0]       funct7,
  input  logic [31:0]      imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic             out_err,
  output logic [CNT_W-1:0] inst_count,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_e;
  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e      state_q, state_d;
  fmt_e        fmt;
  logic        enc_err;
  logic [31:0] imm_eff;
  logic [31:0] enc_inst;
  logic [32:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] inst_count_q, inst_count_d, err_count_q, err_count_d;
  logic        push, pop;

  always_comb begin
    fmt = FMT_R;
    case (opcode)
      7'd103, 7'd3, 7'd19, 7'd115, 7'd15: fmt = FMT_I;
      7'd35:                              fmt = FMT_S;
      7'd99:                              fmt = FMT_B;
      7'd55, 7'd23:                       fmt = FMT_U;
      7'd111:                             fmt = FMT_J;
      default:                            fmt = FMT_R;
    endcase
  end

  // A field is representable when every bit above its top bit matches the sign bit.
  always_comb begin
    enc_err = 1'b0;
    case (fmt)
      FMT_I, FMT_S: enc_err = !((&imm[31:11]) || !(|imm[31:11]));
      FMT_B:        enc_err = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
      FMT_U:        enc_err = |imm[11:0];
      FMT_J:        enc_err = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
      default:      enc_err = 1'b0;
    endcase
  end

  assign imm_eff = (ERR_ZERO_IMM && enc_err) ? 32'd0 : imm;

  always_comb begin
    enc_inst = {funct7, rs2, rs1, funct3, rd, opcode};
    case (fmt)
      FMT_I: enc_inst = {imm_eff[11:0], rs1, funct3, rd, opcode};
      FMT_S: enc_inst = {imm_eff[11:5], rs2, rs1, funct3, imm_eff[4:0], opcode};
      FMT_B: enc_inst = {imm_eff[12], imm_eff[10:5], rs2, rs1, funct3,
                         imm_eff[4:1], imm_eff[11], opcode};
      FMT_U: enc_inst = {imm_eff[31:12], rd, opcode};
      FMT_J: enc_inst = {imm_eff[20], imm_eff[10:1], imm_eff[11], imm_eff[19:12],
                         rd, opcode};
      default: enc_inst = {funct7, rs2, rs1, funct3, rd, opcode};
    endcase
  end

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (push) state_d = ONE;
      ONE: begin
        if (push && !pop)      state_d = FULL;
        else if (!push && pop) state_d = EMPTY;
      end
      FULL:    if (pop) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    in_ready  = (state_q != FULL);
    out_valid = (state_q != EMPTY);
  end

  // Entry payload is {err, inst}; head is what the consumer sees.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    case (state_q)
      EMPTY: if (push) head_d = {enc_err, enc_inst};
      ONE: begin
        if (push && pop) head_d = {enc_err, enc_inst};
        else if (push)   tail_d = {enc_err, enc_inst};
      end
      FULL:    if (pop) head_d = tail_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  always_comb begin
    inst_count_d = inst_count_q;
    err_count_d  = err_count_q;
    if (push && inst_count_q != CNT_MAX)           inst_count_d = inst_count_q + 1'b1;
    if (push && enc_err && err_count_q != CNT_MAX) err_count_d  = err_count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_count_q <= '0;
      err_count_q  <= '0;
    end else begin
      inst_count_q <= inst_count_d;
      err_count_q  <= err_count_d;
    end
  end

  assign out_inst   = head_q[31:0];
  assign out_err    = head_q[32];
  assign inst_count = inst_count_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_riscv_inst_encoder.sv
// Directed and randomized round-trip bench for riscv_inst_encoder.
module tb_riscv_inst_encoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_err;
  logic [15:0] inst_count;
  logic [15:0] err_count;

  int checks;
  int errors;

  riscv_inst_encoder #(.CNT_W(16), .ERR_ZERO_IMM(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2),
    .funct7(funct7), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_err(out_err),
    .inst_count(inst_count), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [4:0] d, input logic [2:0] f3,
                       input logic [4:0] s1, input logic [4:0] s2, input logic [6:0] f7,
                       input logic [31:0] im);
    in_valid = 1'b1;
    opcode = op; rd = d; funct3 = f3; rs1 = s1; rs2 = s2; funct7 = f7; imm = im;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    opcode = 'x; rd = 'x; funct3 = 'x; rs1 = 'x; rs2 = 'x; funct7 = 'x; imm = 'x;
  endtask

  function automatic logic [31:0] decode_imm(input logic [31:0] i);
    case (i[6:0])
      7'd103, 7'd3, 7'd19, 7'd115, 7'd15: return {{20{i[31]}}, i[31:20]};
      7'd35:  return {{20{i[31]}}, i[31:25], i[11:7]};
      7'd99:  return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      7'd55, 7'd23: return {i[31:12], 12'b0};
      7'd111: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic expect_err(input logic [6:0] op, input logic [31:0] im);
    int s;
    s = $signed(im);
    case (op)
      7'd103, 7'd3, 7'd19, 7'd115, 7'd15, 7'd35: return (s < -2048 || s > 2047);
      7'd99:  return (s < -4096 || s > 4095 || im[0]);
      7'd55, 7'd23: return (im[11:0] != 12'd0);
      7'd111: return (s < -1048576 || s > 1048575 || im[0]);
      default: return 1'b0;
    endcase
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; out_ready = 1'b0; idle();
    repeat (3) tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_inst !== 32'd0 || out_err !== 1'b0 ||
        inst_count !== 16'd0 || err_count !== 16'd0) begin
      errors++;
      $display("FAIL reset: valid=%b ready=%b inst=%h err=%b ic=%0d ec=%0d required 0 1 0 0 0 0",
               out_valid, in_ready, out_inst, out_err, inst_count, err_count);
    end
    rst_n = 1'b1;
    tick();
    $display("reset done");
  endtask

  task automatic test_addi();
    out_ready = 1'b1;
    drive(7'd19, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'hFFFF_FFFF);
    tick();
    idle();
    checks++;
    if (out_valid !== 1'b1 || out_inst !== 32'hFFF0_0093 || out_err !== 1'b0 || inst_count !== 16'd1) begin
      errors++;
      $display("FAIL addi: valid=%b inst=%h err=%b ic=%0d required 1 fff00093 0 1",
               out_valid, out_inst, out_err, inst_count);
    end
    $display("addi: inst=%h err=%b", out_inst, out_err);
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL addi_drain: valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_store_lui();
    out_ready = 1'b1;
    drive(7'd35, 5'd0, 3'd2, 5'd1, 5'd2, 7'd0, 32'd8);
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_inst !== 32'h0020_A423 || out_err !== 1'b0) begin
      errors++;
      $display("FAIL store: valid=%b inst=%h err=%b required 1 0020a423 0", out_valid, out_inst, out_err);
    end
    $display("store: inst=%h", out_inst);
    drive(7'd55, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'h1234_5000);
    tick();
    idle();
    checks++;
    if (out_valid !== 1'b1 || out_inst !== 32'h1234_52B7 || out_err !== 1'b0 || inst_count !== 16'd3) begin
      errors++;
      $display("FAIL lui: valid=%b inst=%h err=%b ic=%0d required 1 123452b7 0 3",
               out_valid, out_inst, out_err, inst_count);
    end
    $display("lui: inst=%h", out_inst);
    tick();
  endtask

  task automatic test_jal_branch();
    out_ready = 1'b1;
    drive(7'd111, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'h0000_0800);
    tick();
    checks++;
    if (out_inst !== 32'h0010_00EF || out_err !== 1'b0) begin
      errors++;
      $display("FAIL jal: inst=%h err=%b required 001000ef 0", out_inst, out_err);
    end
    $display("jal: inst=%h", out_inst);
    drive(7'd99, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd3);
    tick();
    idle();
    checks++;
    if (out_valid !== 1'b1 || out_inst !== 32'h0000_0063 || out_err !== 1'b1 || err_count !== 16'd1) begin
      errors++;
      $display("FAIL branch_err: valid=%b inst=%h err=%b ec=%0d required 1 00000063 1 1",
               out_valid, out_inst, out_err, err_count);
    end
    $display("branch: inst=%h err=%b", out_inst, out_err);
    tick();
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_q [3];
    exp_q[0] = 32'h0020_81B3;
    exp_q[1] = 32'h4062_8233;
    exp_q[2] = 32'h0094_43B3;
    out_ready = 1'b0;
    drive(7'd51, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'hDEAD_BEEF);
    tick();
    drive(7'd51, 5'd4, 3'd0, 5'd5, 5'd6, 7'h20, 32'd0);
    tick();
    checks++;
    if (in_ready !== 1'b0 || inst_count !== 16'd7) begin
      errors++;
      $display("FAIL bp_full: in_ready=%b ic=%0d required 0 7", in_ready, inst_count);
    end
    drive(7'd51, 5'd7, 3'd4, 5'd8, 5'd9, 7'd0, 32'd0);
    tick();
    checks++;
    if (inst_count !== 16'd7 || out_inst !== exp_q[0] || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_stall: ic=%0d inst=%h valid=%b required 7 %h 1", inst_count, out_inst, out_valid, exp_q[0]);
    end
    $display("bp stall: inst=%h in_ready=%b", out_inst, in_ready);
    out_ready = 1'b1;
    for (int k = 1; k < 3; k++) begin
      tick();
      if (k == 2) idle();
      checks++;
      if (out_valid !== 1'b1 || out_inst !== exp_q[k] || out_err !== 1'b0) begin
        errors++;
        $display("FAIL bp_out%0d: valid=%b inst=%h err=%b required 1 %h 0", k, out_valid, out_inst, out_err, exp_q[k]);
      end
      $display("bp out%0d: inst=%h", k, out_inst);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || inst_count !== 16'd8) begin
      errors++;
      $display("FAIL bp_drain: valid=%b ic=%0d required 0 8", out_valid, inst_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_inst;
    out_ready = 1'b1;
    drive(7'd19, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd0);
    tick();
    for (int i = 1; i <= 10; i++) begin
      drive(7'd19, 5'(i), 3'd0, 5'd0, 5'd0, 7'd0, 32'(i));
      tick();
      exp_inst = (32'(i) << 20) | (32'(i) << 7) | 32'h13;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_inst !== exp_inst) begin
        errors++;
        $display("FAIL b2b%0d: valid=%b in_ready=%b inst=%h required 1 1 %h",
                 i, out_valid, in_ready, out_inst, exp_inst);
      end
      $display("b2b %0d: inst=%h", i, out_inst);
    end
    idle();
    tick();
    checks++;
    if (out_valid !== 1'b0 || inst_count !== 16'd19) begin
      errors++;
      $display("FAIL b2b_drain: valid=%b ic=%0d required 0 19", out_valid, inst_count);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive(7'd19, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd1);
    tick();
    drive(7'd19, 5'd2, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2);
    tick();
    idle();
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_full: in_ready=%b valid=%b required 0 1", in_ready, out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || inst_count !== 16'd0 || err_count !== 16'd0) begin
      errors++;
      $display("FAIL mid_reset: valid=%b in_ready=%b ic=%0d ec=%0d required 0 1 0 0",
               out_valid, in_ready, inst_count, err_count);
    end
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL mid_stale%0d: valid=%b inst=%h required 0", i, out_valid, out_inst);
      end
    end
    $display("reset mid-stream: valid=%b ic=%0d", out_valid, inst_count);
  endtask

  task automatic test_roundtrip();
    logic [6:0]  ops [8];
    logic [6:0]  op;
    logic [31:0] im;
    logic        e_err;
    int          mode;
    ops[0] = 7'd19; ops[1] = 7'd3; ops[2] = 7'd103; ops[3] = 7'd35;
    ops[4] = 7'd99; ops[5] = 7'd55; ops[6] = 7'd23; ops[7] = 7'd111;
    out_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      op   = ops[$urandom_range(0, 7)];
      mode = $urandom_range(0, 2);
      if (mode == 0)      im = $urandom;
      else if (mode == 1) im = 32'($urandom_range(0, 8191)) - 32'd4096;
      else                im = 32'($urandom_range(0, 2097151)) - 32'd1048576;
      if ((op == 7'd55 || op == 7'd23) && mode != 0) im[11:0] = 12'd0;
      if ((op == 7'd99 || op == 7'd111) && $urandom_range(0, 1) == 1) im[0] = 1'b0;
      e_err = expect_err(op, im);
      drive(op, 5'($urandom), 3'($urandom), 5'($urandom), 5'($urandom), 7'($urandom), im);
      tick();
      idle();
      checks++;
      if (out_valid !== 1'b1 || out_err !== e_err || out_inst[6:0] !== op ||
          (!e_err && decode_imm(out_inst) !== im)) begin
        errors++;
        $display("FAIL roundtrip%0d: op=%0d imm=%h inst=%h err=%b dec=%h required err=%b dec=%h",
                 n, op, im, out_inst, out_err, decode_imm(out_inst), e_err, im);
      end
      $display("rt %0d: op=%0d imm=%h inst=%h err=%b", n, op, im, out_inst, out_err);
      tick();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_addi();
    test_store_lui();
    test_jal_branch();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_roundtrip();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
